// File: rtl/hashcpu_pkg.sv
// Shared constants and types for the hashcpu hazard/forwarding logic.
package hashcpu_pkg;

  localparam int unsigned DEF_NUM_RD  = 3;
  localparam int unsigned DEF_ADDR_W  = 5;
  localparam int unsigned DEF_MAX_LAT = 4;
  localparam int unsigned DEF_CNT_W   = 3;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam int unsigned LAT_ALU  = 2;
  localparam int unsigned LAT_HFNC = DEF_MAX_LAT;

  typedef struct packed {
    logic                 busy;
    logic [DEF_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard/forwarding response bundle for the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_RD = hashcpu_pkg::DEF_NUM_RD,
  parameter int unsigned ADDR_W = hashcpu_pkg::DEF_ADDR_W,
  parameter int unsigned CNT_W  = hashcpu_pkg::DEF_CNT_W
);

  logic                     id_valid;
  logic [NUM_RD-1:0]        id_rd_en;
  logic [NUM_RD*ADDR_W-1:0] id_rd_addr;
  logic                     id_wr_en;
  logic [ADDR_W-1:0]        id_wr_addr;
  logic [CNT_W-1:0]         id_lat;
  logic                     id_flush;
  logic                     stall;
  logic [NUM_RD*2-1:0]      fwd_sel;
  logic [2**ADDR_W-1:0]     busy_vec;

  modport master (
    output id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr, id_lat, id_flush,
    input  stall, fwd_sel, busy_vec
  );

  modport slave (
    input  id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr, id_lat, id_flush,
    output stall, fwd_sel, busy_vec
  );

endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: busy flag plus cycles remaining until its regfile write.
module hazard_sb_entry
  import hashcpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_i,
  input  logic [DEF_CNT_W-1:0] lat_i,
  output sb_entry_t            entry_o
);

  sb_entry_t entry_q, entry_d;

  // A new issue overrides a retirement landing in the same cycle.
  always_comb begin
    entry_d = entry_q;
    if (issue_i) begin
      entry_d.busy = 1'b1;
      entry_d.cnt  = lat_i;
    end else if (entry_q.busy) begin
      if (entry_q.cnt > DEF_CNT_W'(1)) begin
        entry_d.cnt = entry_q.cnt - DEF_CNT_W'(1);
      end else begin
        entry_d.busy = 1'b0;
        entry_d.cnt  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register latency countdown drives bypass select,
// load-use stalls and WAW ordering stalls.
module hazard_scoreboard
  import hashcpu_pkg::*;
#(
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned MAX_LAT = DEF_MAX_LAT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  sb_entry_t           entries [NUM_REGS];
  sb_entry_t           wr_entry;
  logic [CNT_W-1:0]    lat_eff;
  logic [NUM_RD-1:0]   port_stall;
  logic [1:0]          port_fwd [NUM_RD];
  logic                waw_stall;
  logic                stall_c;
  logic                issue_c;
  logic [NUM_RD*2-1:0] fwd_sel_c;
  logic [NUM_REGS-1:0] busy_vec_c;

  // Out-of-range latencies are clamped to the slowest producer.
  assign lat_eff = (sb.id_lat == '0 || sb.id_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : sb.id_lat;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [ADDR_W-1:0] rd_addr;
    sb_entry_t         rd_entry;
    logic              hit;

    assign rd_addr  = sb.id_rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_entry = entries[rd_addr];
    assign hit      = sb.id_valid & sb.id_rd_en[k] & rd_entry.busy;

    // cnt==1: value sits in MEM/WB; cnt==2: in EX/MEM; later: not produced yet.
    assign port_fwd[k]   = !hit                              ? FWD_RF    :
                           (rd_entry.cnt == DEF_CNT_W'(1))   ? FWD_MEMWB :
                           (rd_entry.cnt == DEF_CNT_W'(2))   ? FWD_EXMEM : FWD_RF;
    assign port_stall[k] = hit & (rd_entry.cnt > DEF_CNT_W'(2));
  end

  always_comb begin
    fwd_sel_c = '0;
    for (int k = 0; k < NUM_RD; k++) fwd_sel_c[2*k +: 2] = port_fwd[k];
  end

  // A younger write must not land before an older in-flight one.
  assign wr_entry  = entries[sb.id_wr_addr];
  assign waw_stall = sb.id_wr_en & wr_entry.busy & (lat_eff <= CNT_W'(wr_entry.cnt));

  assign stall_c = sb.id_valid & ((|port_stall) | waw_stall);
  assign issue_c = sb.id_valid & sb.id_wr_en & ~stall_c & ~sb.id_flush & (sb.id_wr_addr != '0);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .issue_i (issue_c && (sb.id_wr_addr == ADDR_W'(r))),
      .lat_i   (DEF_CNT_W'(lat_eff)),
      .entry_o (entries[r])
    );
  end

  always_comb begin
    busy_vec_c = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_vec_c[r] = entries[r].busy;
  end

  assign sb.stall    = stall_c;
  assign sb.fwd_sel  = fwd_sel_c;
  assign sb.busy_vec = busy_vec_c;

  a_lat_legal : assert property (@(posedge clk) disable iff (reset)
    (sb.id_valid && sb.id_wr_en) |-> (sb.id_lat != '0 && sb.id_lat <= CNT_W'(MAX_LAT)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, ALU/HFnc forwarding, WAW, r0, flush.
module tb_hazard_scoreboard;
  import hashcpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] re,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [2:0] lat,
                       input logic fl);
    sb_if.id_valid   = v;
    sb_if.id_rd_en   = re;
    sb_if.id_rd_addr = {a2, a1, a0};
    sb_if.id_wr_en   = we;
    sb_if.id_wr_addr = wa;
    sb_if.id_lat     = lat;
    sb_if.id_flush   = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [2:0] L_ALU  = 3'(LAT_ALU);
  localparam logic [2:0] L_HFNC = 3'(LAT_HFNC);

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #2;
    check("rst_busy", 64'(sb_if.busy_vec), 64'h0);
    check("rst_stall", 64'(sb_if.stall), 64'h0);
    check("rst_fwd", 64'(sb_if.fwd_sel), 64'h0);

    // Reset mid-countdown, with a competing issue on the reset edge
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, L_HFNC, 1'b0);
    #2 check("r5_issue_stall", 64'(sb_if.stall), 64'h0);
    tick();
    idle();
    #2 check("r5_busy", 64'(sb_if.busy_vec), 64'h20);
    tick();
    reset = 1'b1;
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd6, L_ALU, 1'b0);
    tick();
    reset = 1'b0;
    drive(1'b1, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("mid_rst_busy", 64'(sb_if.busy_vec), 64'h0);
    check("mid_rst_stall", 64'(sb_if.stall), 64'h0);
    check("mid_rst_fwd", 64'(sb_if.fwd_sel), 64'h0);
    tick();

    // ALU back-to-back; the issuing instr also reads r3 and sees pre-issue state
    drive(1'b1, 3'b001, 5'd3, 5'd0, 5'd0, 1'b1, 5'd3, L_ALU, 1'b0);
    #2 check("self_read_fwd", 64'(sb_if.fwd_sel), 64'h0);
    tick();
    drive(1'b1, 3'b001, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("alu_rs_fwd", 64'(sb_if.fwd_sel), 64'b000001);
    check("alu_rs_stall", 64'(sb_if.stall), 64'h0);
    tick();
    drive(1'b1, 3'b010, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2 check("alu_rt_fwd", 64'(sb_if.fwd_sel), 64'b001000);
    tick();
    idle();
    #2 check("alu_retired", 64'(sb_if.busy_vec), 64'h0);
    tick();

    // HFnc load-use on Ru: two stall cycles then EX/MEM bypass
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, L_HFNC, 1'b0);
    tick();
    drive(1'b1, 3'b100, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("hf_stall0", 64'(sb_if.stall), 64'h1);
    check("hf_fwd0", 64'(sb_if.fwd_sel), 64'h0);
    tick();
    #2 check("hf_stall1", 64'(sb_if.stall), 64'h1);
    tick();
    #2;
    check("hf_stall2", 64'(sb_if.stall), 64'h0);
    check("hf_fwd2", 64'(sb_if.fwd_sel), 64'b010000);
    tick();
    idle();
    tick();
    #2 check("hf_retired", 64'(sb_if.busy_vec), 64'h0);

    // id_valid / id_rd_en gating
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, L_HFNC, 1'b0);
    tick();
    drive(1'b0, 3'b001, 5'd11, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("novalid_stall", 64'(sb_if.stall), 64'h0);
    check("novalid_fwd", 64'(sb_if.fwd_sel), 64'h0);
    drive(1'b1, 3'b000, 5'd11, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #1 check("norden_stall", 64'(sb_if.stall), 64'h0);
    idle();
    for (int i = 0; i < 4; i++) tick();

    // WAW: r9 lat=4 then r9 lat=2 waits until cnt[9]=1
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, L_HFNC, 1'b0);
    tick();
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, L_ALU, 1'b0);
    #2;
    check("waw_stall0", 64'(sb_if.stall), 64'h1);
    check("waw_busy0", 64'(sb_if.busy_vec[9]), 64'h1);
    tick();
    #2 check("waw_stall1", 64'(sb_if.stall), 64'h1);
    tick();
    #2 check("waw_stall2", 64'(sb_if.stall), 64'h1);
    tick();
    #2 check("waw_release", 64'(sb_if.stall), 64'h0);
    tick();
    drive(1'b1, 3'b001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("waw_busy_after", 64'(sb_if.busy_vec[9]), 64'h1);
    check("waw_new_fwd1", 64'(sb_if.fwd_sel), 64'b000001);
    tick();
    #2 check("waw_new_fwd2", 64'(sb_if.fwd_sel), 64'b000010);
    tick();
    idle();
    #2 check("waw_retired", 64'(sb_if.busy_vec), 64'h0);

    // r0 is never tracked
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, L_HFNC, 1'b0);
    tick();
    drive(1'b1, 3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("r0_busy", 64'(sb_if.busy_vec), 64'h0);
    check("r0_fwd", 64'(sb_if.fwd_sel), 64'h0);
    check("r0_stall", 64'(sb_if.stall), 64'h0);
    tick();

    // Flushed write does not issue
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, L_HFNC, 1'b1);
    tick();
    drive(1'b1, 3'b001, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("flush_busy", 64'(sb_if.busy_vec), 64'h0);
    check("flush_fwd", 64'(sb_if.fwd_sel), 64'h0);
    check("flush_stall", 64'(sb_if.stall), 64'h0);
    tick();

    // All three ports on one ALU result
    drive(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd2, L_ALU, 1'b0);
    tick();
    drive(1'b1, 3'b111, 5'd2, 5'd2, 5'd2, 1'b0, 5'd0, 3'd0, 1'b0);
    #2;
    check("all_fwd", 64'(sb_if.fwd_sel), 64'b010101);
    check("all_stall", 64'(sb_if.stall), 64'h0);
    tick();
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
